// File: rtl/clken_nco_multi.sv
// Multi-channel NCO clock-enable generator gated by a PLL-lock supervisor.
// Each lane owns its inc/phase/accumulator; the top sequences lock, settle and run.

module clken_nco_lane #(
    parameter int ACC_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr,
    input  logic [ACC_WIDTH-1:0] i_inc,
    input  logic [ACC_WIDTH-1:0] i_phase,
    input  logic                 i_load,
    input  logic                 i_step,
    output logic                 o_en
);
    logic [ACC_WIDTH-1:0] r_inc;
    logic [ACC_WIDTH-1:0] r_phase;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_en;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign o_en  = r_en;

    // Load reads the phase register before this edge's write, so a
    // simultaneous config write never leaks into the reload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inc   <= '0;
            r_phase <= '0;
            r_acc   <= '0;
            r_en    <= 1'b0;
        end else begin
            if (i_wr) begin
                r_inc   <= i_inc;
                r_phase <= i_phase;
            end
            if (i_load)
                r_acc <= r_phase;
            else if (i_step)
                r_acc <= w_sum[ACC_WIDTH-1:0];
            r_en <= i_step & w_sum[ACC_WIDTH];
        end
    end
endmodule

module clken_nco_multi #(
    parameter int CHANNELS      = 2,
    parameter int ACC_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CH_IDX_W      = 3
) (
    input  logic                 i_refclk,
    input  logic                 i_rst,
    input  logic                 i_pll_locked,
    input  logic                 i_cfg_valid,
    input  logic [CH_IDX_W-1:0]  i_cfg_chan,
    input  logic [ACC_WIDTH-1:0] i_cfg_inc,
    input  logic [ACC_WIDTH-1:0] i_cfg_phase,
    input  logic                 i_resync,
    output logic [CHANNELS-1:0]  o_clk_en,
    output logic                 o_running,
    output logic                 o_lock_lost
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_IDX_W:0] CH_LIM   = (CH_IDX_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] w_settle_cnt_nxt;
    logic             r_lock_s1;
    logic             r_lock_s2;
    logic             r_lock_lost;
    logic             w_locked_s;
    logic             w_lost_evt;
    logic             w_load;
    logic             w_step;
    logic             w_cfg_ok;

    assign w_locked_s = r_lock_s2;
    assign w_cfg_ok   = i_cfg_valid && ({1'b0, i_cfg_chan} < CH_LIM);

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_lock_s1    <= 1'b0;
            r_lock_s2    <= 1'b0;
            r_state      <= WAIT_LOCK;
            r_settle_cnt <= '0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_lock_s1    <= i_pll_locked;
            r_lock_s2    <= r_lock_s1;
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_lock_lost  <= r_lock_lost | w_lost_evt;
        end
    end

    // Lock loss takes priority over resync; both load and step stay low then.
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = '0;
        w_lost_evt       = 1'b0;
        w_load           = 1'b0;
        w_step           = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_locked_s)
                    w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_settle_cnt == CNT_LAST) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_lost_evt  = 1'b1;
                end else if (i_resync) begin
                    w_load = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    assign o_running   = (r_state == RUN);
    assign o_lock_lost = r_lock_lost;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        clken_nco_lane #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .i_clk  (i_refclk),
            .i_rst  (i_rst),
            .i_wr   (w_cfg_ok && (i_cfg_chan == CH_IDX_W'(g))),
            .i_inc  (i_cfg_inc),
            .i_phase(i_cfg_phase),
            .i_load (w_load),
            .i_step (w_step),
            .o_en   (o_clk_en[g])
        );
    end
endmodule

// File: tb/tb_clken_nco_multi.sv
// Directed bench for clken_nco_multi: arithmetic phase model checked every cycle
// plus hand-computed pulse patterns and latencies.

module tb_clken_nco_multi;
    localparam int CH = 2;
    localparam int W  = 32;
    localparam int S  = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [IW-1:0] cfg_chan = '0;
    logic [W-1:0]  cfg_inc = '0;
    logic [W-1:0]  cfg_phase = '0;
    logic          resync = 1'b0;
    logic [CH-1:0] clk_en;
    logic          running;
    logic          lock_lost;

    int total = 0;
    int bad   = 0;
    int ecount = 0;

    clken_nco_multi #(
        .CHANNELS(CH), .ACC_WIDTH(W), .SETTLE_CYCLES(S), .CH_IDX_W(IW)
    ) dut (
        .i_refclk(clk), .i_rst(rst), .i_pll_locked(pll),
        .i_cfg_valid(cfg_valid), .i_cfg_chan(cfg_chan),
        .i_cfg_inc(cfg_inc), .i_cfg_phase(cfg_phase), .i_resync(resync),
        .o_clk_en(clk_en), .o_running(running), .o_lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: lock delayed two cycles, phase tracked as plain integer sums.
    localparam longint unsigned MODW = 64'd1 << W;
    longint unsigned m_acc[CH], m_inc[CH], m_phase[CH];
    logic [CH-1:0] m_en;
    bit m_s1, m_s2, m_lost;
    int m_mode, m_cnt;   // 0 waiting, 1 settling, 2 running

    always @(posedge clk) begin
        longint unsigned sum;
        ecount++;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i] = 0; m_inc[i] = 0; m_phase[i] = 0;
            end
            m_en = '0; m_s1 = 0; m_s2 = 0; m_lost = 0; m_mode = 0; m_cnt = 0;
        end else begin
            m_en = '0;
            case (m_mode)
                0: begin
                    m_cnt = 0;
                    if (m_s2) m_mode = 1;
                end
                1: begin
                    if (!m_s2) begin
                        m_mode = 0; m_cnt = 0;
                    end else if (m_cnt == S - 1) begin
                        m_mode = 2;
                        for (int i = 0; i < CH; i++) m_acc[i] = m_phase[i];
                    end else m_cnt++;
                end
                default: begin
                    if (!m_s2) begin
                        m_mode = 0; m_lost = 1;
                    end else if (resync) begin
                        for (int i = 0; i < CH; i++) m_acc[i] = m_phase[i];
                    end else begin
                        for (int i = 0; i < CH; i++) begin
                            sum = m_acc[i] + m_inc[i];
                            m_en[i] = (sum >= MODW);
                            m_acc[i] = sum % MODW;
                        end
                    end
                end
            endcase
            if (cfg_valid && cfg_chan < CH) begin
                m_inc[cfg_chan] = cfg_inc;
                m_phase[cfg_chan] = cfg_phase;
            end
            m_s2 = m_s1;
            m_s1 = pll;
        end
        #2;
        chk("clk_en", clk_en, m_en);
        chk("running", running, m_mode == 2);
        chk("lock_lost", lock_lost, m_lost);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input int ch, input logic [W-1:0] inc, input logic [W-1:0] ph);
        tick();
        cfg_valid = 1'b1; cfg_chan = IW'(ch); cfg_inc = inc; cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_run(input string nm, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (running) ok = 1;
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    task automatic window8(output logic [7:0] e0, output logic [7:0] e1);
        for (int k = 0; k < 8; k++) begin
            tick();
            e0[k] = clk_en[0];
            e1[k] = clk_en[1];
        end
    endtask

    initial begin
        int t0, d, cnt, dbl;
        bit ok, prev;
        logic [7:0] e0, e1;

        repeat (3) tick();
        chk("rst_running", running, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_lock_lost", lock_lost, 0);
        rst = 1'b0;

        // Channel 0 at half rate; out-of-range channel write must be ignored.
        cfg(0, 32'h8000_0000, 32'h0);
        cfg(CH, 32'hFFFF_FFFF, 32'h1234_5678);

        tick();
        pll = 1'b1;
        t0 = ecount;
        wait_run("lock_wait", ok);
        chk("run_latency", ecount - t0 - 1, 2 + S);
        window8(e0, e1);
        chk("toggle_ch0", e0, 8'hAA);
        chk("idle_ch1", e1, 8'h00);

        // Phase alignment: ch1 half a turn ahead.
        cfg(0, 32'h4000_0000, 32'h0);
        cfg(1, 32'h4000_0000, 32'h8000_0000);
        tick(); resync = 1'b1;
        tick(); resync = 1'b0;
        window8(e0, e1);
        chk("align_ch0", e0, 8'h88);
        chk("align_ch1", e1, 8'h22);

        // Config write on the resync edge: old phase is reloaded.
        tick();
        resync = 1'b1; cfg_valid = 1'b1; cfg_chan = 0;
        cfg_inc = 32'h4000_0000; cfg_phase = 32'h4000_0000;
        tick(); resync = 1'b0; cfg_valid = 1'b0;
        window8(e0, e1);
        chk("cc_oldphase_ch0", e0, 8'h88);
        chk("cc_oldphase_ch1", e1, 8'h22);
        tick(); resync = 1'b1;
        tick(); resync = 1'b0;
        window8(e0, e1);
        chk("cc_newphase_ch0", e0, 8'h44);

        // Fractional rate: 20100 adds of 4294967 wrap exactly 20 times.
        cfg(0, 32'd4294967, 32'h0);
        cfg(1, 32'h0, 32'h0);
        tick(); resync = 1'b1;
        tick(); resync = 1'b0;
        cnt = 0; dbl = 0; prev = 0;
        for (int k = 0; k < 20100; k++) begin
            tick();
            if (clk_en[0]) cnt++;
            if (clk_en[0] && prev) dbl++;
            prev = clk_en[0];
        end
        chk("frac_count", cnt, 20);
        chk("frac_width", dbl, 0);

        // One-cycle lock drop during RUN.
        cfg(0, 32'h8000_0000, 32'h0);
        tick(); pll = 1'b0; d = ecount + 1;
        tick(); pll = 1'b1;
        tick();
        tick();
        chk("loss_running", running, 0);
        chk("loss_clk_en", clk_en, 0);
        chk("loss_flag", lock_lost, 1);
        wait_run("relock_wait", ok);
        chk("relock_latency", ecount - d, 3 + S);
        chk("loss_sticky", lock_lost, 1);

        // Reset mid-run wipes configuration.
        repeat (4) tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("mrst_running", running, 0);
        chk("mrst_clk_en", clk_en, 0);
        chk("mrst_lock_lost", lock_lost, 0);
        wait_run("mrst_wait", ok);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (clk_en != 0) cnt++;
        end
        chk("mrst_no_pulses", cnt, 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clken_nco_multi.md
Name: clken_nco_multi

Overview:
- Multi-channel numerically-controlled clock-enable generator. It runs in the PLL output domain and derives N independent fractional-rate enable pulses from one fast clock, for example a 32.768 kHz tick from 32.768 MHz.
- Each channel has a runtime-programmable increment and a programmable initial phase.
- Generation is gated by a PLL-lock supervisor, so no enables are emitted while the clock is unstable.

Parameters:
- CHANNELS, 2, number of independent enable channels (1..8).
- ACC_WIDTH, 32, phase-accumulator width in bits; the carry out of the MSB produces the enable.
- SETTLE_CYCLES, 1024, consecutive locked cycles required before generation starts (≥1).
- CH_IDX_W, 3, width of the channel-select field (≥ clog2(CHANNELS)).

Ports:
- refclk  in  1  single clock; all logic in this domain.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock indication; synchronised internally with a 2-flop chain.
- cfg_valid  in  1  one-cycle strobe writing channel configuration.
- cfg_chan  in  CH_IDX_W  channel index for the write.
- cfg_inc  in  ACC_WIDTH  new increment for that channel.
- cfg_phase  in  ACC_WIDTH  new initial phase for that channel.
- resync  in  1  one-cycle strobe; reloads every accumulator with its phase together.
- clk_en  out  CHANNELS  per-channel one-cycle enable pulses.
- running  out  1  high while in state RUN.
- lock_lost  out  1  sticky flag; set on any lock loss during RUN, cleared only by rst.

Behaviour:
- Reset values (rst high at a clock edge):
  - clk_en = 0, running = 0, lock_lost = 0.
  - All accumulators = 0, all inc registers = 0, all phase registers = 0.
  - Settle counter = 0; state = WAIT_LOCK.
- Lock synchroniser: locked_s is pll_locked after 2 refclk flops. All lock decisions below use locked_s.
- State machine:
  - WAIT_LOCK: settle counter held at 0. Go to SETTLE when locked_s = 1.
  - SETTLE: counter increments each cycle while locked_s = 1.
    - If locked_s = 0, return to WAIT_LOCK and clear the counter.
    - When the counter reaches SETTLE_CYCLES-1 with locked_s still 1, go to RUN.
    - On that transition, every acc[i] is loaded with phase[i].
  - RUN:
    - running = 1.
    - Each cycle, {carry, acc[i]} = acc[i] + inc[i], computed at ACC_WIDTH+1 bits. acc[i] wraps modulo 2^ACC_WIDTH.
    - clk_en[i] is registered from carry, so it is high the cycle after the wrapping add.
    - If locked_s = 0: go to WAIT_LOCK, set lock_lost, force clk_en to 0 on the same edge, clear running.
- Enable latency:
  - The first possible clk_en pulse is 2 cycles after RUN entry.
  - Cycle 1 is the first add from phase[i]; cycle 2 is the registered output.
  - With inc = 0, the channel never pulses.
- Configuration writes:
  - Accepted in any state.
  - On the edge where cfg_valid = 1 and cfg_chan < CHANNELS, inc[cfg_chan] and phase[cfg_chan] are written.
  - The new inc is used from the following cycle's add. The accumulator is not disturbed, so there is no glitch pulse.
  - A write with cfg_chan ≥ CHANNELS is ignored silently.
- resync:
  - In RUN: every acc[i] ← phase[i] on that edge, replacing the add, and clk_en = 0 on the next cycle.
  - Ignored outside RUN.
- Simultaneous cfg_valid and resync on the same edge: resync loads the OLD phase; the new values take effect afterwards. Software must resync again to apply a new phase.
- Simultaneous resync and lock loss: lock loss wins.
- Average rate: f_en[i] = f_refclk × inc[i] / 2^ACC_WIDTH. Pulses are always exactly one cycle wide and never back-to-back unless inc ≥ 2^(ACC_WIDTH-1).
- A mid-operation rst behaves identically to power-up; all configuration is lost.

Test Plan:
- Lock and run, single channel:
  - Setup: SETTLE_CYCLES = 16; cfg ch0 inc = 0x8000_0000, phase = 0; pll_locked raised at cycle 10.
  - Required: running rises at cycle 10+2+16; clk_en[0] then toggles every 2 cycles; clk_en[1] stays 0 (inc 0).
- Fractional rate:
  - Setup: ch0 inc = 4294967 (about 32.768 kHz from 32.768 MHz).
  - Required: over 10,000,000 RUN cycles, exactly 10,000 ± 1 pulses, each one cycle wide.
- Phase alignment via resync:
  - Setup: ch0 and ch1 both inc = 0x4000_0000; ch0 phase = 0, ch1 phase = 0x8000_0000; resync pulsed.
  - Required: both channels pulse every 4 cycles, with ch1 leading ch0 by 2 cycles.
- Lock loss mid-run:
  - Stimulus: drop pll_locked for 1 cycle during RUN.
  - Required: within 3 cycles, running = 0, clk_en = 0, lock_lost = 1.
  - On re-lock, SETTLE repeats fully and lock_lost stays 1 until rst.
- Invalid or concurrent configuration:
  - A cfg write with cfg_chan = CHANNELS leaves all inc and phase registers unchanged.
  - A cfg write on the same edge as resync: accumulators take the old phase.
- Reset mid-run:
  - Stimulus: assert rst for 1 cycle while channels are pulsing.
  - Required: next cycle all outputs are 0 and state is WAIT_LOCK; with inc cleared, no pulses after re-lock until reconfigured.
